// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, accumulator FSM state type and saturating narrow helper
// for the fully-connected datapath.
package fc_pkg;

    localparam int FC_SIZE      = 16;
    localparam int FC_PRECISION = 11;
    localparam int FC_MAX_LEN   = 1024;
    localparam int FC_CW        = $clog2(FC_MAX_LEN + 1);
    localparam int FC_ACC_W     = FC_SIZE + FC_CW + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} fc_acc_state_t;

    // Returns {sat, value} for the default widths.
    function automatic logic [FC_SIZE:0] sat_narrow(input logic [FC_ACC_W-1:0] acc);
        logic fits;
        fits = &acc[FC_ACC_W-1:FC_SIZE-1] | ~|acc[FC_ACC_W-1:FC_SIZE-1];
        return fits ? {1'b0, acc[FC_SIZE-1:0]} :
               acc[FC_ACC_W-1] ? {2'b11, {(FC_SIZE-1){1'b0}}} :
                                 {2'b10, {(FC_SIZE-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fc_sat_narrow.sv
// fc_sat_narrow: combinational signed IN_W -> OUT_W saturator; flags clipping.
module fc_sat_narrow #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  acc,
    output logic [OUT_W-1:0] value,
    output logic             sat
);

    logic fits;

    // In range exactly when all bits from the result's sign bit upward agree.
    always_comb begin
        fits  = &acc[IN_W-1:OUT_W-1] | ~|acc[IN_W-1:OUT_W-1];
        sat   = ~fits;
        value = fits ? acc[OUT_W-1:0] :
                acc[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end

endmodule

// File: rtl/fc_accumulator.sv
// fc_accumulator: sums a programmed number of fixed-point products onto a bias
// and returns one saturated result per job over a ready/valid handshake.
module fc_accumulator
    import fc_pkg::*;
#(
    parameter int SIZE      = FC_SIZE,
    parameter int PRECISION = FC_PRECISION,
    parameter int MAX_LEN   = FC_MAX_LEN,
    localparam int CW       = $clog2(MAX_LEN + 1),
    localparam int ACC_W    = SIZE + CW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   length,
    input  logic [SIZE-1:0] bias,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] product,
    input  logic            product_ovf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] result,
    output logic            result_ovf,
    output logic            busy
);

    if (PRECISION >= SIZE) begin : g_bad_precision
        $error("fc_accumulator: PRECISION must be below SIZE");
    end

    fc_acc_state_t    state_q, state_d;
    logic [CW-1:0]    len_q, len_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [SIZE-1:0]  res_q, res_d;
    logic             res_ovf_q, res_ovf_d;
    logic [SIZE-1:0]  sat_value;
    logic             sat;
    logic             xfer;

    fc_sat_narrow #(.IN_W(ACC_W), .OUT_W(SIZE)) u_sat (
        .acc   (acc_d),
        .value (sat_value),
        .sat   (sat)
    );

    always_comb begin
        xfer      = in_valid && state_q == ACCUM;
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        if (state_q == IDLE && start) begin
            len_d    = length;
            cnt_d    = '0;
            acc_d    = {{(ACC_W-SIZE){bias[SIZE-1]}}, bias};
            sticky_d = 1'b0;
            state_d  = length == '0 ? OUT : ACCUM;
        end else if (xfer) begin
            acc_d    = acc_q + {{(ACC_W-SIZE){product[SIZE-1]}}, product};
            cnt_d    = cnt_q + 1'b1;
            sticky_d = sticky_q | product_ovf;
            state_d  = cnt_q == len_q - 1'b1 ? OUT : ACCUM;
        end else if (state_q == OUT && out_ready) begin
            state_d = IDLE;
        end
        // Capture the saturated sum only on entry to OUT so it stays stable until accepted.
        res_d     = state_d == OUT && state_q != OUT ? sat_value : res_q;
        res_ovf_d = state_d == OUT && state_q != OUT ? sticky_d | sat : res_ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign in_ready   = state_q == ACCUM;
    assign out_valid  = state_q == OUT;
    assign busy       = state_q != IDLE;
    assign result     = res_q;
    assign result_ovf = res_ovf_q;

endmodule

// File: tb/tb_fc_accumulator.sv
// tb_fc_accumulator: directed checks of fc_accumulator with hand-computed results.
module tb_fc_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] length = '0;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] product = '0;
    logic        product_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        result_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    fc_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .product_ovf(product_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_ovf(result_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [10:0] len, input logic [15:0] b);
        start = 1'b1; length = len; bias = b;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] p, input logic ovf);
        in_valid = 1'b1; product = p; product_ovf = ovf;
        step();
        in_valid = 1'b0; product_ovf = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_ovf"}, result_ovf, 0);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        idle_outputs("reset");

        // 1: 1 + 0.5 - 0.25 = 1.25
        go(3, 16'h0000);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 1);
        feed(16'h0800, 0);
        feed(16'h0400, 0);
        chk("t1_not_early", out_valid, 0);
        feed(16'hFE00, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_in_ready_out", in_ready, 0);
        chk("t1_result", result, 16'h0A00);
        chk("t1_ovf", result_ovf, 0);
        accept();
        chk("t1_done_valid", out_valid, 0);
        chk("t1_done_busy", busy, 0);

        // 2: positive and negative saturation
        go(20, 16'h0000);
        for (int i = 0; i < 20; i++) feed(16'h0800, 0);
        chk("t2p_valid", out_valid, 1);
        chk("t2p_result", result, 16'h7FFF);
        chk("t2p_ovf", result_ovf, 1);
        accept();
        go(20, 16'h0000);
        for (int i = 0; i < 20; i++) feed(16'hF800, 0);
        chk("t2n_result", result, 16'h8000);
        chk("t2n_ovf", result_ovf, 1);
        accept();

        // 3: zero-length job returns the bias
        go(0, 16'h0400);
        chk("t3_valid", out_valid, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_result", result, 16'h0400);
        chk("t3_ovf", result_ovf, 0);
        accept();
        chk("t3_idle", busy, 0);

        // 4: input gaps, output back-pressure, ignored start pulses
        go(4, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_gap_ready", in_ready, 1);
            chk("t4_gap_valid", out_valid, 0);
            feed(16'h0100, 0);
        end
        for (int i = 0; i < 5; i++) begin
            start = i[0]; length = 11'd1; bias = 16'h7000;
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_ready", in_ready, 0);
            chk("t4_hold_result", result, 16'h0400);
        end
        start = 1'b0;
        accept();
        chk("t4_accept_valid", out_valid, 0);
        chk("t4_accept_busy", busy, 0);
        step();
        chk("t4_single_accept", out_valid, 0);

        // 5: sticky product overflow
        go(2, 16'h0000);
        feed(16'h0100, 0);
        feed(16'h0100, 1);
        chk("t5_result", result, 16'h0200);
        chk("t5_ovf", result_ovf, 1);
        accept();

        // 6: reset mid-job, then a fresh job
        go(5, 16'h0000);
        feed(16'h0100, 0);
        feed(16'h0100, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_outputs("t6_rst");
        go(1, 16'h0800);
        feed(16'h0800, 0);
        chk("t6_valid", out_valid, 1);
        chk("t6_result", result, 16'h1000);
        chk("t6_ovf", result_ovf, 0);
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
